// File: rtl/mem_debug_pkg.sv
// mem_debug_pkg: sequencer state encoding, byte-lane constants, word-index to byte-address helper
package mem_debug_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RSTP, RUN, RD_ADDR, RD_WAIT, RD_OUT, DONE} state_t;
  localparam int DEF_DW = 32;
  localparam int BYTES = DEF_DW / 8;
  localparam int ADDR_SHIFT = $clog2(BYTES);
  function automatic logic [63:0] idx2addr(input logic [31:0] idx, input int shift);
    return {32'b0, idx} << shift;
  endfunction
endpackage

// File: rtl/mem_debug_cycle_cnt.sv
// mem_debug_cycle_cnt: saturating loadable down-counter; ports clk/rst_n, load+val, en, tc (count==0)
module mem_debug_cycle_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] val,
  output logic         tc
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= val;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  assign tc = cnt == '0;
endmodule

// File: rtl/mem_debug_sequencer.sv
// mem_debug_sequencer: load NUM_CH RAMs from in_* stream over dbg_* port, reset/run core (core_rst, core_halt), dump RAMs on out_* stream
module mem_debug_sequencer
  import mem_debug_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int WORDS      = 4096,
  parameter int RST_CYCLES = 5,
  parameter int RUN_CYCLES = 200000
) (
  input  logic                       CPU_CLK,
  input  logic                       CPU_RST_N,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DW-1:0]              in_data,
  input  logic                       in_last,
  output logic [NUM_CH*AW-1:0]       dbg_a2,
  output logic [NUM_CH*DW-1:0]       dbg_wd2,
  output logic [NUM_CH*(DW/8)-1:0]   dbg_we2,
  input  logic [NUM_CH*DW-1:0]       dbg_rd2,
  input  logic                       core_halt,
  output logic                       core_rst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DW-1:0]              out_data,
  output logic [$clog2(NUM_CH):0]    out_ch,
  output logic [$clog2(WORDS):0]     out_idx,
  output logic                       out_last,
  output logic                       busy,
  output logic [31:0]                run_count
);
  localparam int BY = DW / 8;
  localparam int SH = $clog2(BY);
  localparam int CW = $clog2(NUM_CH) + 1;
  localparam int IW = $clog2(WORDS) + 1;
  localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);
  state_t state;
  logic [CW-1:0] ch, nch;
  logic [IW-1:0] idx, nidx;
  logic ch_end, last_word, tc, cnt_load;
  assign ch_end = in_valid && (in_last || idx == LAST_IDX);
  assign last_word = ch == LAST_CH && idx == LAST_IDX;
  assign nidx = idx == LAST_IDX ? '0 : idx + 1'b1;
  assign nch = idx == LAST_IDX ? ch + 1'b1 : ch;
  // reload the shared counter on entry to RSTP and on entry to RUN
  assign cnt_load = !abort && ((state == LOAD && ch_end && ch == LAST_CH) || (state == RSTP && tc));
  mem_debug_cycle_cnt u_cnt (
    .clk  (CPU_CLK),
    .rst_n(CPU_RST_N),
    .load (cnt_load),
    .en   (state == RSTP || state == RUN),
    .val  (state == LOAD ? 32'(RST_CYCLES - 1) : 32'(RUN_CYCLES - 1)),
    .tc   (tc)
  );
  always_ff @(posedge CPU_CLK or negedge CPU_RST_N)
    if (!CPU_RST_N) begin
      state <= IDLE;
      ch <= '0;
      idx <= '0;
      core_rst <= 1'b1;
      in_ready <= 1'b0;
      dbg_a2 <= '0;
      dbg_wd2 <= '0;
      dbg_we2 <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_ch <= '0;
      out_idx <= '0;
      out_last <= 1'b0;
      busy <= 1'b0;
      run_count <= '0;
    end else begin
      dbg_we2 <= '0;
      if (abort) begin
        state <= IDLE;
        in_ready <= 1'b0;
        out_valid <= 1'b0;
        out_last <= 1'b0;
        core_rst <= 1'b1;
        busy <= 1'b0;
      end else
        case (state)
          IDLE, DONE: if (start) begin
            state <= LOAD;
            ch <= '0;
            idx <= '0;
            run_count <= '0;
            in_ready <= 1'b1;
            busy <= 1'b1;
          end
          LOAD: if (in_valid) begin
            dbg_a2[ch*AW +: AW] <= AW'(idx2addr(32'(idx), SH));
            dbg_wd2[ch*DW +: DW] <= in_data;
            dbg_we2[ch*BY +: BY] <= '1;
            if (ch_end) begin
              idx <= '0;
              if (ch == LAST_CH) begin
                state <= RSTP;
                in_ready <= 1'b0;
              end else ch <= ch + 1'b1;
            end else idx <= nidx;
          end
          RSTP: if (tc) begin
            state <= RUN;
            core_rst <= 1'b0;
          end
          RUN: begin
            run_count <= run_count + 1'b1;
            if (core_halt || tc) begin
              state <= RD_ADDR;
              ch <= '0;
              idx <= '0;
              dbg_a2[AW-1:0] <= '0;
              core_rst <= 1'b1;
            end
          end
          // address is already on dbg_a2 here, so read data lands during RD_WAIT
          RD_ADDR: state <= RD_WAIT;
          RD_WAIT: begin
            state <= RD_OUT;
            out_data <= dbg_rd2[ch*DW +: DW];
            out_ch <= ch;
            out_idx <= idx;
            out_last <= last_word;
            out_valid <= 1'b1;
          end
          RD_OUT: if (out_ready) begin
            out_valid <= 1'b0;
            out_last <= 1'b0;
            if (last_word) begin
              state <= DONE;
              busy <= 1'b0;
            end else begin
              state <= RD_ADDR;
              ch <= nch;
              idx <= nidx;
              dbg_a2[nch*AW +: AW] <= AW'(idx2addr(32'(nidx), SH));
            end
          end
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_debug_sequencer.sv
// tb_mem_debug_sequencer: table-driven and random self-checking bench with RAM model and expected-content shadow
module tb_mem_debug_sequencer;
  localparam int NC = 2;
  localparam int W = 8;
  localparam int RC = 5;
  typedef struct {
    int n0;
    int n1;
    int halt;
    int mode;
    int smid;
    int exp_run;
  } vec_t;
  logic clk = 0, rst_n = 0, init = 1;
  logic start = 0, abort = 0, in_valid = 0, in_last = 0, core_halt = 0, out_ready = 0;
  logic in_ready, core_rst, out_valid, out_last, busy;
  logic [31:0] in_data = 0, out_data, run_count;
  logic [63:0] dbg_a2, dbg_wd2, dbg_rd2;
  logic [7:0] dbg_we2;
  logic [1:0] out_ch;
  logic [3:0] out_idx;
  logic [31:0] ram[NC][W];
  logic [31:0] exp_mem[NC][W];
  int total = 0, bad = 0;
  vec_t tv[6];
  always #5 clk = ~clk;
  mem_debug_sequencer #(.NUM_CH(2), .DW(32), .AW(32), .WORDS(8), .RST_CYCLES(5), .RUN_CYCLES(50)) dut (
    .CPU_CLK(clk), .CPU_RST_N(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .dbg_a2(dbg_a2), .dbg_wd2(dbg_wd2), .dbg_we2(dbg_we2), .dbg_rd2(dbg_rd2),
    .core_halt(core_halt), .core_rst(core_rst),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_idx(out_idx), .out_last(out_last),
    .busy(busy), .run_count(run_count)
  );
  always @(posedge clk)
    for (int c = 0; c < NC; c++) begin
      if (init) for (int i = 0; i < W; i++) ram[c][i] <= (c == 0) ? 32'(i) : 32'h100 + 32'(i);
      else if (dbg_we2[c*4 +: 4] == 4'hf) ram[c][dbg_a2[c*32+2 +: 3]] <= dbg_wd2[c*32 +: 32];
      dbg_rd2[c*32 +: 32] <= ram[c][dbg_a2[c*32+2 +: 3]];
    end
  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask
  task automatic fail_to(input string nm);
    total++;
    bad++;
    $display("FAIL %s timeout", nm);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_core_rst"}, core_rst, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_out_ch"}, out_ch, 0);
    chk({tag, "_out_idx"}, out_idx, 0);
    chk({tag, "_we2"}, dbg_we2, 0);
    chk({tag, "_a2"}, dbg_a2, 0);
    chk({tag, "_wd2"}, dbg_wd2, 0);
    chk({tag, "_run_count"}, run_count, 0);
  endtask
  task automatic do_start;
    start = 1;
    step;
    start = 0;
  endtask
  task automatic load_all(input int n0, input int n1, input int abort_at);
    int mc = 0, mk = 0, g = 0, n;
    bit hs;
    logic [31:0] d;
    while (mc < NC && g < 500) begin
      n = (mc == 0) ? n0 : n1;
      if (mc == 0 && mk == abort_at) begin
        in_valid = 1;
        in_data = $urandom;
        abort = 1;
        step;
        abort = 0;
        in_valid = 0;
        chk("abort_ld_we2", dbg_we2, 0);
        chk("abort_ld_busy", busy, 0);
        chk("abort_ld_ready", in_ready, 0);
        chk("abort_ld_core_rst", core_rst, 1);
        return;
      end
      d = $urandom;
      in_valid = $urandom_range(0, 3) != 0;
      in_data = d;
      in_last = (mk == n - 1) && (n < W);
      hs = in_valid && in_ready;
      step;
      g++;
      if (hs) begin
        chk("ld_we2", dbg_we2, 64'(8'hf << (mc * 4)));
        chk("ld_a2", dbg_a2[mc*32 +: 32], mk * 4);
        chk("ld_wd2", dbg_wd2[mc*32 +: 32], d);
        exp_mem[mc][mk] = d;
        mk++;
        if (mk == n) begin
          mc++;
          mk = 0;
        end
      end else chk("ld_we2_idle", dbg_we2, 0);
    end
    in_valid = 0;
    in_last = 0;
    if (g >= 500) fail_to("load");
    else chk("ld_done_ready", in_ready, 0);
  endtask
  task automatic run_phase(input int halt_at, input int smid, output int rc, output int low);
    int g = 0;
    rc = 0;
    low = 0;
    while (core_rst && g < 100) begin
      step;
      rc++;
      g++;
    end
    while (!core_rst && g < 200) begin
      low++;
      core_halt = low == halt_at;
      start = smid != 0 && low == 10;
      step;
      g++;
      if (start) chk("start_in_run_busy", busy, 1);
    end
    core_halt = 0;
    start = 0;
    if (low == 0 || g >= 200) fail_to("run");
  endtask
  task automatic dump(input int mode, input int abort_after);
    int cnt = 0, g = 0;
    bit tog = 0, hs;
    chk("dump_core_rst", core_rst, 1);
    while (cnt < 2 * W && g < 400) begin
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? tog : 1'($urandom_range(0, 1));
      tog = !tog;
      if (abort_after >= 0 && cnt == abort_after && out_valid) begin
        abort = 1;
        step;
        abort = 0;
        out_ready = 0;
        chk("abort_dump_valid", out_valid, 0);
        chk("abort_dump_busy", busy, 0);
        chk("abort_dump_core_rst", core_rst, 1);
        chk("abort_dump_we2", dbg_we2, 0);
        return;
      end
      hs = out_valid && out_ready;
      if (out_valid) begin
        chk("dump_ch", out_ch, cnt / W);
        chk("dump_idx", out_idx, cnt % W);
        chk("dump_data", out_data, exp_mem[cnt/W][cnt%W]);
        chk("dump_last", out_last, cnt == 2 * W - 1);
      end
      step;
      g++;
      if (hs) cnt++;
    end
    out_ready = 0;
    if (g >= 400) fail_to("dump");
    else begin
      chk("done_busy", busy, 0);
      chk("done_valid", out_valid, 0);
      chk("done_core_rst", core_rst, 1);
    end
  endtask
  task automatic run_rec(input vec_t r, input int abort_dump);
    int rc, low;
    do_start;
    chk("start_busy", busy, 1);
    chk("start_ready", in_ready, 1);
    chk("start_run_count", run_count, 0);
    load_all(r.n0, r.n1, -1);
    run_phase(r.halt, r.smid, rc, low);
    chk("rst_cycles", rc, RC);
    chk("run_low_cycles", low, r.exp_run);
    chk("run_count", run_count, r.exp_run);
    dump(r.mode, abort_dump);
  endtask
  initial begin
    int g;
    tv[0] = '{8, 3, 0, 0, 0, 50};
    tv[1] = '{8, 8, 17, 1, 0, 17};
    tv[2] = '{2, 5, 0, 2, 1, 50};
    tv[3] = '{1, 1, 1, 2, 0, 1};
    tv[4] = '{5, 8, 50, 1, 0, 50};
    tv[5] = '{8, 1, 99, 2, 0, 50};
    for (int c = 0; c < NC; c++)
      for (int i = 0; i < W; i++) exp_mem[c][i] = (c == 0) ? 32'(i) : 32'h100 + 32'(i);
    repeat (3) step;
    chk_reset("rst");
    init = 0;
    rst_n = 1;
    step;
    run_rec(tv[0], -1);
    run_rec(tv[1], -1);
    do_start;
    load_all(8, 8, 4);
    run_rec(tv[2], -1);
    run_rec(tv[3], -1);
    run_rec(tv[4], 5);
    do_start;
    load_all(3, 2, -1);
    g = 0;
    while (core_rst && g < 50) begin
      step;
      g++;
    end
    if (g >= 50) fail_to("reach_run");
    repeat (7) step;
    #2 rst_n = 0;
    #1 chk_reset("rst_in_run");
    @(negedge clk) rst_n = 1;
    step;
    run_rec(tv[5], -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_debug_sequencer.md
Name: mem_debug_sequencer

Overview:
- Synthesizable replacement for the simulation-only BRAM load/run/dump sequence.
- Drives the debug port (A2/WD2/WE2/RD2) of NUM_CH block RAMs. Typical use is two RAMs: ch0 = DataRAM, ch1 = InstRAM.
- Sequence per start: load each RAM from a word stream, pulse reset on RV32Core, run for a cycle budget or until halt, then stream every RAM's contents out.
- Sits between a host link (UART/JTAG bridge) and RV32Core on the FPGA top level.

Parameters:
- NUM_CH, 2: number of RAMs; channel 0 is loaded and dumped first.
- DW, 32: RAM word width; a multiple of 8.
- AW, 32: debug address width (byte address).
- WORDS, 4096: words per RAM, loaded and dumped per channel.
- RST_CYCLES, 5: cycles core_rst stays asserted after loading; ≥1.
- RUN_CYCLES, 200000: maximum cycles core_rst stays low.

Ports:
- CPU_CLK  in  1  clock.
- CPU_RST_N  in  1  asynchronous active-low reset.
- start  in  1  pulse; accepted only in IDLE or DONE.
- abort  in  1  any state → IDLE next cycle.
- in_valid  in  1  load stream valid.
- in_ready  out  1  load stream ready.
- in_data  in  DW  load word.
- in_last  in  1  last word for the current channel.
- dbg_a2  out  NUM_CH*AW  per-channel byte address; slice ch = [ch*AW +: AW].
- dbg_wd2  out  NUM_CH*DW  per-channel write data.
- dbg_we2  out  NUM_CH*(DW/8)  per-channel byte enables.
- dbg_rd2  in  NUM_CH*DW  per-channel read data; 1-cycle synchronous read.
- core_halt  in  1  core finished; ends RUN early.
- core_rst  out  1  active-high reset to RV32Core CPU_RST.
- out_valid  out  1  dump stream valid.
- out_ready  in  1  dump stream ready.
- out_data  out  DW  dumped word.
- out_ch  out  $clog2(NUM_CH)+1  channel of out_data.
- out_idx  out  $clog2(WORDS)+1  word index of out_data.
- out_last  out  1  last word of the last channel.
- busy  out  1  high in any state other than IDLE or DONE.
- run_count  out  32  cycles spent in RUN during the last run.

Behaviour:
- Reset values (CPU_RST_N low, asynchronous):
  - state = IDLE; core_rst = 1; all dbg_we2 = 0; dbg_a2 = 0; dbg_wd2 = 0.
  - in_ready = 0; out_valid = 0; out_ch = 0; out_idx = 0; out_last = 0; busy = 0; run_count = 0.
- core_rst is 1 in every state except RUN.
- States: IDLE, LOAD, RSTP, RUN, RD_ADDR, RD_WAIT, RD_OUT, DONE.
- IDLE/DONE, start = 1 → LOAD; ch = 0, idx = 0, run_count cleared.
- LOAD:
  - in_ready = 1.
  - On in_valid & in_ready: dbg_a2[ch] = idx*(DW/8); dbg_wd2[ch] = in_data; dbg_we2[ch] = all-ones for exactly that cycle.
  - All other channels have we2 = 0, and we2 = 0 on every cycle without a handshake.
  - Channel ends when the written word has in_last = 1 or idx = WORDS-1. Then ch++, idx = 0.
  - Words not written keep their previous RAM contents.
  - After the final channel ends → RSTP.
- RSTP: counter runs RST_CYCLES cycles, then → RUN.
- RUN:
  - core_rst = 0; run_count increments every RUN cycle.
  - Exit when core_halt = 1 (that cycle is counted) or run_count reaches RUN_CYCLES → RD_ADDR with ch = 0, idx = 0; core_rst = 1 from the next cycle.
- Dump, 3 cycles per word minimum:
  - RD_ADDR: drive dbg_a2[ch] = idx*(DW/8), we2 = 0.
  - RD_WAIT: wait one cycle for the synchronous read.
  - RD_OUT: register out_data = dbg_rd2[ch], out_ch, out_idx; out_valid = 1. out_data/out_ch/out_idx stay stable until out_ready.
  - On handshake, advance idx, or ch when idx = WORDS-1. Next state RD_ADDR, or DONE after the last word.
  - out_last = 1 only for ch = NUM_CH-1, idx = WORDS-1.
- Address arithmetic: idx width $clog2(WORDS)+1, zero-extended and shifted by log2(DW/8). No wrap; idx never exceeds WORDS-1.
- Simultaneous events:
  - abort has priority over start and all handshakes.
  - core_halt in the same cycle that the budget expires: single exit, count identical.
  - start while busy is ignored.
- Abort or reset mid-operation:
  - we2 = 0 and out_valid = 0 from the next cycle; core_rst = 1.
  - A partially loaded RAM is left as is.

Decomposition:
- Package mem_debug_pkg holds:
  - the state enum;
  - localparams BYTES = DW/8 and ADDR_SHIFT = $clog2(BYTES);
  - the helper function idx2addr.
- One sub-module, mem_debug_cycle_cnt: loadable down-counter shared by RSTP and RUN, with terminal-count flag.

Test Plan:
- Basic load: NUM_CH = 2, WORDS = 8; stream 8 words 0x1000+i to ch0, 3 words with in_last on the 3rd to ch1.
  - ch0 gets 8 WE pulses, addresses 0x00..0x1C.
  - ch1 gets 3 pulses at 0x00..0x08; words 3..7 untouched.
- Run budget: RUN_CYCLES = 50, core_halt = 0.
  - core_rst is low for exactly 50 cycles; run_count = 50; preceded by 5 reset cycles.
- Early halt: core_halt at RUN cycle 17 → run_count = 17; dump begins.
- Dump backpressure: RAM model preloaded ch0[i] = i, ch1[i] = 0x100+i; out_ready toggles every other cycle.
  - 16 words in order (ch, idx) = (0,0)..(1,7); no duplicates or drops; out_last only on (1,7).
- In-flight abort: abort mid-LOAD at idx 4, then again mid-dump.
  - IDLE next cycle; we2 = 0; core_rst = 1.
  - A following start reloads from ch0 idx0.
- Reset and start-while-busy:
  - CPU_RST_N low during RUN → all outputs at reset values immediately.
  - A start pulse during RUN is ignored; run_count is unaffected.
